// File: rtl/arcfour_key_dispatcher.sv
// Arcfour key dispatcher: hands candidate keys to a pool of cracking cores, tracks which cores
// are busy, counts completions and stops the search on the first reported success.
module arcfour_key_dispatcher #(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned KEY_LENGTH = 3,
    parameter int unsigned RAM_WIDTH  = 8,
    parameter int unsigned KEY_BITS   = 22
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic                                      key_select,
    input  logic [KEY_LENGTH*RAM_WIDTH-1:0]           switch_key,
    output logic [NUM_CORES-1:0]                      core_start,
    output logic [NUM_CORES*KEY_LENGTH*RAM_WIDTH-1:0] core_key,
    output logic [NUM_CORES-1:0]                      core_abort,
    input  logic [NUM_CORES-1:0]                      core_done,
    input  logic [NUM_CORES-1:0]                      core_success,
    output logic                                      busy,
    output logic                                      found,
    output logic                                      exhausted,
    output logic [KEY_LENGTH*RAM_WIDTH-1:0]           found_key,
    output logic [KEY_BITS:0]                         keys_tried,
    output logic [2:0]                                stateTap
);
    localparam int unsigned KW = KEY_LENGTH * RAM_WIDTH;
    localparam int unsigned CW = KEY_BITS + 1;
    localparam logic [CW-1:0] LastKey = CW'((64'd1 << KEY_BITS) - 64'd1);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StDispatch  = 3'd1,
        StDrain     = 3'd2,
        StFound     = 3'd3,
        StExhausted = 3'd4
    } state_e;

    state_e                    state_q, state_d;
    logic                      start_prev_q, armed_q;
    logic                      mode_q, mode_d;
    logic [KW-1:0]             switch_key_q, switch_key_d;
    logic [CW-1:0]             next_key_q, next_key_d;
    logic [NUM_CORES-1:0]      busy_q, busy_d;
    logic [NUM_CORES-1:0]      core_start_q, core_start_d;
    logic [NUM_CORES-1:0]      core_abort_q, core_abort_d;
    logic [NUM_CORES*KW-1:0]   core_key_q, core_key_d;
    logic [KW-1:0]             found_key_q, found_key_d;
    logic [CW-1:0]             keys_tried_q, keys_tried_d;

    logic [NUM_CORES-1:0]      done_valid, success;
    logic [CW-1:0]             done_cnt;
    int unsigned               win_idx, free_idx;
    logic                      win_hit, free_hit, start_edge;

    // Qualify completions, count them and pick the lowest winning / lowest idle core.
    always_comb begin
        done_valid = core_done & busy_q;
        success    = done_valid & core_success;
        done_cnt   = '0;
        win_idx    = 0;
        win_hit    = 1'b0;
        free_idx   = 0;
        free_hit   = 1'b0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            done_cnt = done_cnt + CW'(done_valid[i]);
            if (success[i] && !win_hit) begin
                win_idx = i;
                win_hit = 1'b1;
            end
            // busy_q is the cycle-start view, so a core finishing now is not yet free
            if (!busy_q[i] && !free_hit) begin
                free_idx = i;
                free_hit = 1'b1;
            end
        end
        // armed_q masks a start level that was already high when reset released
        start_edge = start & ~start_prev_q & armed_q;
    end

    // Next-state and dispatch decisions.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        switch_key_d = switch_key_q;
        next_key_d   = next_key_q;
        busy_d       = busy_q & ~done_valid;
        core_start_d = '0;
        core_abort_d = '0;
        core_key_d   = core_key_q;
        found_key_d  = found_key_q;
        keys_tried_d = keys_tried_q;

        case (state_q)
            StIdle, StFound, StExhausted: begin
                if (start_edge) begin
                    state_d      = StDispatch;
                    mode_d       = key_select;
                    switch_key_d = switch_key;
                    next_key_d   = '0;
                    keys_tried_d = '0;
                    found_key_d  = '0;
                end
            end
            StDispatch, StDrain: begin
                keys_tried_d = keys_tried_q + done_cnt;
                if (win_hit) begin
                    found_key_d  = core_key_q[win_idx*KW +: KW];
                    // cores finishing this cycle need no abort
                    core_abort_d = busy_q & ~done_valid;
                    busy_d       = '0;
                    state_d      = StFound;
                end else if (state_q == StDispatch) begin
                    if (mode_q) begin
                        if (!busy_q[0]) begin
                            core_start_d[0]     = 1'b1;
                            busy_d[0]           = 1'b1;
                            core_key_d[0 +: KW] = switch_key_q;
                            state_d             = StDrain;
                        end
                    end else if (free_hit) begin
                        core_start_d[free_idx]         = 1'b1;
                        busy_d[free_idx]               = 1'b1;
                        core_key_d[free_idx*KW +: KW]  = KW'(next_key_q[KEY_BITS-1:0]);
                        next_key_d                     = next_key_q + 1'b1;
                        if (next_key_q == LastKey) begin
                            state_d = StDrain;
                        end
                    end
                end else if (busy_q == '0) begin
                    state_d = StExhausted;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            start_prev_q <= 1'b0;
            armed_q      <= 1'b0;
            mode_q       <= 1'b0;
            switch_key_q <= '0;
            next_key_q   <= '0;
            busy_q       <= '0;
            core_start_q <= '0;
            core_abort_q <= '0;
            core_key_q   <= '0;
            found_key_q  <= '0;
            keys_tried_q <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start;
            armed_q      <= 1'b1;
            mode_q       <= mode_d;
            switch_key_q <= switch_key_d;
            next_key_q   <= next_key_d;
            busy_q       <= busy_d;
            core_start_q <= core_start_d;
            core_abort_q <= core_abort_d;
            core_key_q   <= core_key_d;
            found_key_q  <= found_key_d;
            keys_tried_q <= keys_tried_d;
        end
    end

    assign core_start = core_start_q;
    assign core_abort = core_abort_q;
    assign core_key   = core_key_q;
    assign found_key  = found_key_q;
    assign keys_tried = keys_tried_q;
    assign busy       = (state_q == StDispatch) || (state_q == StDrain);
    assign found      = (state_q == StFound);
    assign exhausted  = (state_q == StExhausted);
    assign stateTap   = state_q;

endmodule

// File: doc/arcfour_key_dispatcher.md
ARCFOUR_KEY_DISPATCHER -- requirements
Module: arcfour_key_dispatcher

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4: number of downstream arcfour cracking cores, 1..16.
REQ-002 SHALL have parameter KEY_LENGTH, default 3: key bytes per core key.
REQ-003 SHALL have parameter RAM_WIDTH, default 8: bits per key byte.
REQ-004 SHALL have parameter KEY_BITS, default 22: swept key bits, 1..KEY_LENGTH*RAM_WIDTH; upper key bits always 0 in sweep mode.
REQ-005 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low; asserted at 0.
REQ-007 SHALL have port start, input, 1: level; rising edge detected internally, begins a search.
REQ-008 SHALL have port key_select, input, 1: sampled at accepted start edge; 0 = sweep, 1 = single switch key.
REQ-009 SHALL have port switch_key, input, KEY_LENGTH*RAM_WIDTH: key used in single mode, sampled at accepted start edge.
REQ-010 SHALL have port core_start, output, NUM_CORES: one-cycle dispatch pulse per core.
REQ-011 SHALL have port core_key, output, NUM_CORES*KEY_LENGTH*RAM_WIDTH: per-core key, held stable from dispatch until that core's done.
REQ-012 SHALL have port core_abort, output, NUM_CORES: one-cycle pulse to busy cores on a find.
REQ-013 SHALL have port core_done, input, NUM_CORES: one-cycle completion pulse per core.
REQ-014 SHALL have port core_success, input, NUM_CORES: valid only with the matching core_done bit.
REQ-015 SHALL have port busy, output, 1: high in DISPATCH or DRAIN.
REQ-016 SHALL have port found, output, 1: high in FOUND.
REQ-017 SHALL have port exhausted, output, 1: high in EXHAUSTED.
REQ-018 SHALL have port found_key, output, KEY_LENGTH*RAM_WIDTH: key of the successful core.
REQ-019 SHALL have port keys_tried, output, KEY_BITS+1: count of core_done pulses since last accepted start.
REQ-020 SHALL have port stateTap, output, 3: current state encoding.

Function
REQ-021 SHALL implement states IDLE=0, DISPATCH=1, DRAIN=2, FOUND=3, EXHAUSTED=4.
REQ-022 SHALL accept a start edge only in IDLE, FOUND or EXHAUSTED; edges in DISPATCH or DRAIN are ignored.
REQ-023 On an accepted start SHALL go to DISPATCH next cycle, latch mode and switch_key, set next_key=0, clear keys_tried and found_key.
REQ-024 SHALL keep a per-core busy bit: set on dispatch, cleared on core_done or abort.
REQ-025 In DISPATCH SHALL, each cycle, dispatch to at most one core: the lowest-index core idle at cycle start; core_start and core_key update on the same edge.
REQ-026 A core whose core_done arrives in cycle N SHALL become dispatchable no earlier than cycle N+1.
REQ-027 In sweep mode SHALL send keys 0,1,...,2^KEY_BITS-1 in order, each exactly once, with next_key incremented per dispatch.
REQ-028 After dispatching key 2^KEY_BITS-1 SHALL go to DRAIN; next_key shall not wrap.
REQ-029 In single mode SHALL dispatch switch_key to core 0 only, once, then go to DRAIN.
REQ-030 On any core_done with core_success in DISPATCH or DRAIN SHALL latch found_key from the lowest-index successful core, pulse core_abort for every other busy core, and enter FOUND next cycle; no dispatch that cycle.
REQ-031 In DRAIN with all busy bits clear and no success SHALL enter EXHAUSTED.
REQ-032 keys_tried SHALL add popcount(core_done) each cycle outside IDLE, FOUND and EXHAUSTED.
REQ-033 SHALL hold found_key, keys_tried and state in FOUND or EXHAUSTED until the next accepted start.
REQ-034 SHALL ignore core_done for non-busy cores, with no count and no capture.

Reset
REQ-035 While reset=0 SHALL force state IDLE, all busy bits 0, core_start/core_abort/core_key/found_key/keys_tried 0, busy/found/exhausted 0, and edge detector history 0.
REQ-036 Reset asserted mid-search SHALL abandon the search without core_abort; a start held high across reset release SHALL NOT count as an edge.

Verification
REQ-037 NUM_CORES=2, KEY_BITS=2, sweep, cores done 3 cycles after start, never succeed -> keys 0,1,2,3 sent to cores 0,1,0,1; EXHAUSTED; keys_tried=4.
REQ-038 Same config, core 1 reports success on key 3 -> found=1, found_key=3, no further core_start, abort only to other busy cores.
REQ-039 key_select=1, switch_key=0x0A0B0C, core 0 succeeds -> exactly one core_start on core 0 with that key; found_key=0x0A0B0C.
REQ-040 Both cores report success in the same cycle with keys 4 and 5 -> found_key = core 0's key.
REQ-041 start toggled during DISPATCH -> ignored; sequence unchanged; restart from FOUND clears keys_tried and redispatches from key 0.
REQ-042 reset pulsed low mid-DISPATCH -> all outputs 0 immediately and stay 0 until a new start edge.
